// File: rtl/des_encrypt_if.sv
// Interface for the DES encryptor: operands, the enable/done/ack handshake,
// the ciphertext, and a debug view of the controller state.
interface des_encrypt_if;
  logic [7:0][7:0] message;
  logic [7:0][7:0] DESkey;
  logic            enable;
  logic            ack;
  logic [7:0][7:0] encrypted;
  logic            done;
  logic            busy;
  logic [1:0]      state_dbg;

  modport master (
    output message, DESkey, enable, ack,
    input  encrypted, done, busy, state_dbg
  );

  modport slave (
    input  message, DESkey, enable, ack,
    output encrypted, done, busy, state_dbg
  );
endinterface

// File: rtl/des_encrypt.sv
// Iterative DES encryptor: ROUNDS_PER_CYCLE Feistel rounds per clock,
// with subkeys derived on the fly by rotating the C/D key halves.
module des_encrypt #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  des_encrypt_if.slave  bus
);

  if (!(ROUNDS_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_rounds
    $error("des_encrypt: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Handshake: enable is a start request honoured only in IDLE (inputs are
  // captured on that edge); done stays high with encrypted stable until the
  // edge where ack is seen, then the block returns to IDLE. Requests arriving
  // in any other state are dropped, not queued.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Permutation tables list source bit numbers, 1 = MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // S1..S8 back to back, each 4 rows of 16 columns.
  localparam int SBOX [512] = '{
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_T[j]];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_T[j]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_T[j]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_T[j]];
    return y;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one place; every other round by two.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input int round_no);
    if (round_no == 1 || round_no == 2 || round_no == 9 || round_no == 16)
      return {x[26:0], x[27]};
    return {x[25:0], x[27:26]};
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    for (int j = 0; j < 48; j++) x[47-j] = r[32-E_T[j]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      s[31-4*b -: 4] = 4'(SBOX[b*64 + int'({six[5], six[0]})*16 + int'(six[4:1])]);
    end
    for (int j = 0; j < 32; j++) p[31-j] = s[32-P_T[j]];
    return p;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  rnd_q, rnd_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] enc_q, enc_d;
  logic        done_q, done_d;

  logic [63:0] ip_w;
  logic [55:0] cd_w;
  logic [31:0] l_t, r_t, tmp_t;
  logic [27:0] c_t, d_t;
  logic [47:0] k_t;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    enc_d   = enc_q;
    done_d  = done_q;

    ip_w  = ip_f(bus.message);
    cd_w  = pc1_f(bus.DESkey);

    // Unrolled chain of rounds rnd+1 .. rnd+ROUNDS_PER_CYCLE.
    l_t   = l_q;
    r_t   = r_q;
    c_t   = c_q;
    d_t   = d_q;
    tmp_t = '0;
    k_t   = '0;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      c_t   = rotl28(c_t, int'(rnd_q) + k + 1);
      d_t   = rotl28(d_t, int'(rnd_q) + k + 1);
      k_t   = pc2_f({c_t, d_t});
      tmp_t = r_t;
      r_t   = l_t ^ feistel(r_t, k_t);
      l_t   = tmp_t;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          l_d     = ip_w[63:32];
          r_d     = ip_w[31:0];
          c_d     = cd_w[55:28];
          d_d     = cd_w[27:0];
          rnd_d   = 5'd0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        l_d   = l_t;
        r_d   = r_t;
        c_d   = c_t;
        d_d   = d_t;
        rnd_d = rnd_q + 5'(ROUNDS_PER_CYCLE);
        if (rnd_d == 5'd16) state_d = S_FINAL;
      end
      S_FINAL: begin
        enc_d   = fp_f({r_q, l_q});
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.ack) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      enc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
    end
  end

  assign bus.encrypted = enc_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == S_ROUND) || (state_q == S_FINAL);
  assign bus.state_dbg = state_q;

endmodule
